motor_passo_ctrl: RTL and testbench
===================================

Name: motor_passo_ctrl

Overview:
- Parametrised stepper-motor sequencer for one 4-coil unipolar motor.
- Supports three excitation modes: wave, full-step and half-step.
- Has a programmable step period and a counted move of N steps with a start/busy/done handshake.
- Tracks a signed position count and can optionally hold the coils energised when idle.
- Sits between the motion-command logic and the coil driver pins.

Parameters:
- PER_W, 16, width of step-period input (clock cycles per step).
- CNT_W, 16, width of step-count input.
- POS_W, 24, width of signed position counter.
- HOLD_EN, 1, 1 = drive last coil pattern while idle; 0 = drive 4'b0000 while idle.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  pulse; requests a move; sampled only in IDLE.
- stop  in  1  abort request; sampled only in RUN.
- en  in  1  pause control; 0 freezes the step timer while in RUN.
- dir  in  1  direction; 1 = forward (phase index +), 0 = reverse; latched at start.
- modo  in  2  excitation mode; 00 wave, 01 full, 10 half, 11 = wave; latched at start.
- periodo  in  PER_W  clocks per step; 0 is treated as 1; latched at start.
- passos  in  CNT_W  number of steps to take; latched at start.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse when a move completes normally.
- sinal  out  4  registered coil drive pattern.
- pos  out  POS_W  signed position; +1 per forward step, -1 per reverse step.

Behaviour:
- Reset, synchronous on the clk edge with rst=1:
  - state=IDLE; phase index idx=0; timer=0; remaining-step count=0.
  - pos=0, busy=0, done=0, sinal=4'b0000.
  - rst overrides everything, including a move in progress.
- Half-step table, idx 0..7: 1000, 1100, 0100, 0110, 0010, 0011, 0001, 1001.
- Mode alignment, applied at the start edge:
  - wave: idx := idx with bit0 cleared; each step is idx±2.
  - full: idx := idx with bit0 set; each step is idx±2.
  - half: idx unchanged; each step is idx±1.
  - idx wraps modulo 8.
- FSM has two states, IDLE and RUN.
- IDLE, start=1:
  - Latch dir, modo, periodo (0→1) and passos; apply mode alignment.
  - If passos==0: stay IDLE and pulse done on the next cycle; no step, pos unchanged.
  - Otherwise go to RUN with timer=0.
- RUN, en=1:
  - timer increments each cycle.
  - On the edge where timer==P-1: take one step (update idx and pos, decrement count) and reset timer to 0.
  - The first step's idx update lands P edges after the start edge.
- RUN, en=0: timer, idx and count hold; busy stays 1.
- Move completion:
  - The final step edge also sets state=IDLE and done=1 for exactly one cycle.
  - busy falls at that same edge.
- stop=1 in RUN:
  - Go to IDLE on the next edge; no done pulse.
  - A step due on that same edge is not taken.
  - If stop and start are both high in RUN, stop wins.
- start while in RUN is ignored. stop while in IDLE is ignored. modo, dir and periodo changes while in RUN are ignored.
- sinal is registered from the current state and idx, so it lags idx by one cycle:
  - RUN: table[idx].
  - IDLE with HOLD_EN=1: table[idx], except 0000 from rst until the first start.
  - IDLE with HOLD_EN=0: 0000.
- pos wraps in two's complement modulo 2^POS_W. Alignment at start never changes pos.

Decomposition:
- Package motor_passo_pkg:
  - modo_t enum (WAVE, FULL, HALF).
  - estado_t enum (IDLE, RUN).
  - Constant 8×4 half-step table and a function tabela(idx).
- Sub-module motor_passo_temporizador (PER_W):
  - Inputs: clear, run, periodo.
  - Output: tick, high on the cycle timer==P-1.
- The top level holds the FSM, idx, count, pos and output registers.

Test Plan:
- rst, then start with modo=10, dir=1, periodo=3, passos=4 → idx takes 1,2,3,4 at edges 3,6,9,12 after start; sinal 1100, 0100, 0110, 0010 one cycle later; done at edge 12; pos=4.
- From idx=4: start with modo=00, dir=0, periodo=1, passos=3 → idx 2,0,6; sinal 0100, 1000, 0001; pos 4→1.
- start with modo=01 from idx=0 → aligned idx=1; forward steps give sinal 0110, 0011, 1001, 1100.
- RUN with periodo=2, passos=5; drop en for 4 cycles after step 2 → no idx/pos change during the pause; done exactly 4 cycles later than the un-paused run.
- stop after 2 of 6 steps → IDLE, no done, pos=2; sinal holds (HOLD_EN=1) or reads 0000 (HOLD_EN=0).
- passos=0 → done one cycle after start, busy never 1. periodo=0 behaves as 1. rst mid-move → all outputs 0 the next cycle. pos at 2^(POS_W-1)-1 plus one forward step → wraps to the minimum negative value.

Source files
------------

// File: rtl/motor_passo_pkg.sv
// Shared types, half-step coil table and index helpers
// for the stepper-motor sequencer.
package motor_passo_pkg;

  typedef enum logic [1:0] {
    WAVE = 2'd0,
    FULL = 2'd1,
    HALF = 2'd2
  } modo_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } estado_t;

  localparam logic [3:0] TABELA [8] = '{
    4'b1000, 4'b1100, 4'b0100, 4'b0110,
    4'b0010, 4'b0011, 4'b0001, 4'b1001
  };

  function automatic logic [3:0] tabela(
    input logic [2:0] idx
  );
    return TABELA[idx];
  endfunction

  // 2'b11 is folded onto wave drive
  function automatic modo_t decod_modo(
    input logic [1:0] m
  );
    unique case (m)
      2'b01:   return FULL;
      2'b10:   return HALF;
      default: return WAVE;
    endcase
  endfunction

  // wave uses even (single-coil) entries,
  // full uses odd (two-coil) entries
  function automatic logic [2:0] alinhar(
    input logic [2:0] idx,
    input modo_t      m
  );
    unique case (m)
      WAVE:    return {idx[2:1], 1'b0};
      FULL:    return {idx[2:1], 1'b1};
      default: return idx;
    endcase
  endfunction

endpackage

// File: rtl/motor_passo_temporizador.sv
// Step-period timer: tick is high on the cycle timer==P-1.
// Ports: clk, rst, clear, run, periodo (P, nonzero), tick.
module motor_passo_temporizador #(
  parameter int PER_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             run,
  input  logic [PER_W-1:0] periodo,
  output logic             tick
);

  logic [PER_W-1:0] r_timer;
  logic             w_fim;

  assign w_fim = (r_timer == periodo - PER_W'(1));
  assign tick  = run && w_fim;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_timer <= '0;
    end else if (run) begin
      r_timer <= w_fim ? '0 : r_timer + PER_W'(1);
    end
  end

endmodule

// File: rtl/motor_passo_ctrl.sv
// Stepper sequencer: counted moves in wave/full/half mode.
// Ports: clk, rst, start, stop, en, dir, modo, periodo,
// passos in; busy, done, sinal (coils), pos (signed) out.
module motor_passo_ctrl
  import motor_passo_pkg::*;
#(
  parameter int PER_W   = 16,
  parameter int CNT_W   = 16,
  parameter int POS_W   = 24,
  parameter bit HOLD_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             en,
  input  logic             dir,
  input  logic [1:0]       modo,
  input  logic [PER_W-1:0] periodo,
  input  logic [CNT_W-1:0] passos,
  output logic             busy,
  output logic             done,
  output logic [3:0]       sinal,
  output logic [POS_W-1:0] pos
);

  estado_t          r_state;
  modo_t            r_modo;
  logic             r_dir;
  logic [PER_W-1:0] r_per;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_idx;
  logic [POS_W-1:0] r_pos;
  logic             r_done;
  logic [3:0]       r_sinal;
  logic             r_started;

  logic             w_tick;
  modo_t            w_modo;
  logic [2:0]       w_passo;
  logic [2:0]       w_idx_nx;
  logic [POS_W-1:0] w_pos_nx;

  assign w_modo   = decod_modo(modo);
  assign w_passo  = (r_modo == HALF) ? 3'd1 : 3'd2;
  assign w_idx_nx = r_dir ? r_idx + w_passo
                          : r_idx - w_passo;
  assign w_pos_nx = r_dir ? r_pos + POS_W'(1)
                          : r_pos - POS_W'(1);

  motor_passo_temporizador #(
    .PER_W (PER_W)
  ) u_tmr (
    .clk     (clk),
    .rst     (rst),
    .clear   (r_state != RUN),
    .run     ((r_state == RUN) && en),
    .periodo (r_per),
    .tick    (w_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_modo    <= WAVE;
      r_dir     <= 1'b0;
      r_per     <= PER_W'(1);
      r_cnt     <= '0;
      r_idx     <= '0;
      r_pos     <= '0;
      r_done    <= 1'b0;
      r_sinal   <= 4'b0000;
      r_started <= 1'b0;
    end else begin
      r_done <= 1'b0;
      // pattern follows the pre-edge state/idx
      if (r_state == RUN || (HOLD_EN && r_started))
        r_sinal <= tabela(r_idx);
      else
        r_sinal <= 4'b0000;

      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_modo    <= w_modo;
            r_dir     <= dir;
            r_per     <= (periodo == '0) ? PER_W'(1)
                                         : periodo;
            r_cnt     <= passos;
            r_idx     <= alinhar(r_idx, w_modo);
            r_started <= 1'b1;
            if (passos == '0)
              r_done  <= 1'b1;
            else
              r_state <= RUN;
          end
        end
        RUN: begin
          if (stop) begin
            r_state <= IDLE;
          end else if (w_tick) begin
            r_idx <= w_idx_nx;
            r_pos <= w_pos_nx;
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) begin
              r_state <= IDLE;
              r_done  <= 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy  = (r_state == RUN);
  assign done  = r_done;
  assign sinal = r_sinal;
  assign pos   = r_pos;

endmodule

// File: tb/tb_motor_passo_ctrl.sv
// Self-checking bench for motor_passo_ctrl: vector table of
// chained moves plus pause, stop, zero-step and reset cases.
module tb_motor_passo_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, stop, en, dir;
  logic [1:0]  modo;
  logic [15:0] periodo, passos;
  logic        busy, done, busy2, done2;
  logic [3:0]  sinal, sinal2;
  logic [23:0] pos;
  logic [3:0]  pos2;

  int n_tests = 0;
  int n_fail  = 0;
  int e_pos   = 0;

  always #5 clk = ~clk;

  motor_passo_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .en(en), .dir(dir), .modo(modo), .periodo(periodo),
    .passos(passos), .busy(busy), .done(done),
    .sinal(sinal), .pos(pos)
  );

  // narrow position, coils released when idle
  motor_passo_ctrl #(.POS_W(4), .HOLD_EN(1'b0)) dut2 (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .en(en), .dir(dir), .modo(modo), .periodo(periodo),
    .passos(passos), .busy(busy2), .done(done2),
    .sinal(sinal2), .pos(pos2)
  );

  typedef struct {
    logic [1:0]      modo;
    logic            dir;
    logic [15:0]     per;
    logic [15:0]     passos;
    int              cyc;
    int              pos;
    logic [0:3][3:0] sig;
  } vec_t;

  vec_t vs [6];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, got, exp);
    end
  endtask

  task automatic chk_pos();
    chk("pos", 32'(pos), 32'(e_pos) & 32'hFF_FFFF);
    chk("pos4", 32'(pos2), 32'(e_pos) & 32'hF);
  endtask

  initial begin
    int p, nsig, done_at;
    logic seen;

    vs[0] = '{2'b10, 1'b1, 16'd3, 16'd4, 12, 4,
      {4'b1100, 4'b0100, 4'b0110, 4'b0010}};
    vs[1] = '{2'b00, 1'b0, 16'd1, 16'd3, 3, 1,
      {4'b0100, 4'b1000, 4'b0001, 4'b0000}};
    vs[2] = '{2'b00, 1'b1, 16'd1, 16'd1, 1, 2,
      {4'b1000, 4'b0000, 4'b0000, 4'b0000}};
    vs[3] = '{2'b01, 1'b1, 16'd2, 16'd4, 8, 6,
      {4'b0110, 4'b0011, 4'b1001, 4'b1100}};
    vs[4] = '{2'b10, 1'b0, 16'd0, 16'd2, 2, 4,
      {4'b1000, 4'b1001, 4'b0000, 4'b0000}};
    vs[5] = '{2'b11, 1'b1, 16'd1, 16'd4, 4, 8,
      {4'b1000, 4'b0100, 4'b0010, 4'b0001}};

    rst = 1'b1; start = 1'b0; stop = 1'b0; en = 1'b1;
    dir = 1'b0; modo = 2'b00; periodo = '0; passos = '0;
    cyc(); cyc();
    rst = 1'b0;
    cyc(); cyc();
    chk("rst_sinal", 32'(sinal), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk_pos();

    for (int v = 0; v < 6; v++) begin
      modo = vs[v].modo; dir = vs[v].dir;
      periodo = vs[v].per; passos = vs[v].passos;
      start = 1'b1;
      cyc();
      start = 1'b0;
      modo = 2'b00; dir = ~vs[v].dir; periodo = 16'd7;
      chk("busy_start", 32'(busy), 32'h1);
      p = (vs[v].per == 0) ? 1 : int'(vs[v].per);
      nsig = (vs[v].passos < 4) ? int'(vs[v].passos) : 4;
      done_at = -1;
      for (int k = 1; k <= 200; k++) begin
        cyc();
        if (k > 1 && (k - 1) % p == 0 && (k - 1) / p <= nsig)
          chk($sformatf("v%0d_sinal", v), 32'(sinal),
              32'(vs[v].sig[(k - 1) / p - 1]));
        if (done_at >= 0) begin
          chk("done_pulse", 32'(done), 32'h0);
          chk("busy_end", 32'(busy), 32'h0);
          chk("sinal_nohold", 32'(sinal2), 32'h0);
          break;
        end
        if (done) done_at = k;
      end
      chk($sformatf("v%0d_latency", v),
          32'(done_at), 32'(vs[v].cyc));
      e_pos = vs[v].pos;
      chk_pos();
    end

    // pause: idx 6, pos 8; en low for edges 5..8
    modo = 2'b10; dir = 1'b1; periodo = 16'd2;
    passos = 16'd5; start = 1'b1;
    cyc();
    start = 1'b0;
    done_at = -1;
    for (int k = 1; k <= 60; k++) begin
      en = (k >= 5 && k <= 8) ? 1'b0 : 1'b1;
      cyc();
      if (k >= 5 && k <= 8) begin
        chk("pause_pos", 32'(pos), 32'd10);
        chk("pause_busy", 32'(busy), 32'h1);
      end
      if (done) begin
        done_at = k;
        break;
      end
    end
    en = 1'b1;
    chk("pause_latency", 32'(done_at), 32'd14);
    e_pos = 13;
    chk_pos();
    cyc();

    // stop after 2 of 6 steps, start also high
    modo = 2'b10; dir = 1'b1; periodo = 16'd1;
    passos = 16'd6; start = 1'b1;
    cyc();
    start = 1'b0;
    cyc(); cyc();
    stop = 1'b1; start = 1'b1;
    cyc();
    stop = 1'b0; start = 1'b0;
    chk("stop_busy", 32'(busy), 32'h0);
    e_pos = 15;
    chk_pos();
    seen = done;
    for (int k = 0; k < 4; k++) begin
      cyc();
      seen = seen | done;
    end
    chk("stop_nodone", 32'(seen), 32'h0);
    chk("stop_hold", 32'(sinal), 32'b0011);
    chk("stop_nohold", 32'(sinal2), 32'h0);
    chk_pos();

    // zero-step move: idx 5 aligned to 4
    modo = 2'b00; passos = 16'd0; start = 1'b1;
    cyc();
    start = 1'b0;
    chk("zero_done", 32'(done), 32'h1);
    chk("zero_busy", 32'(busy), 32'h0);
    cyc();
    chk("zero_done_end", 32'(done), 32'h0);
    chk("zero_busy2", 32'(busy), 32'h0);
    chk("zero_align", 32'(sinal), 32'b0010);
    chk_pos();

    // reset in the middle of a move
    modo = 2'b10; periodo = 16'd2; passos = 16'd5;
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc(); cyc(); cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("mrst_sinal", 32'(sinal), 32'h0);
    chk("mrst_busy", 32'(busy), 32'h0);
    chk("mrst_done", 32'(done), 32'h0);
    e_pos = 0;
    chk_pos();
    cyc(); cyc();
    chk("mrst_idle_sinal", 32'(sinal), 32'h0);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
